// File: rtl/if_id_stage.sv
// if_id_stage: fetch-side pipeline front end.
// Holds the PC register and the IF/ID pipeline register. It applies the
// hazard-unit controls (PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush) and
// the branch redirect resolved in ID. It also keeps saturating stall and flush
// counters for performance debug. All outputs come straight from flops.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PC_EN_IF,
    input  logic             reg_FD_EN,
    input  logic             reg_FD_stall,
    input  logic             reg_FD_flush,
    input  logic             Branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      inst_IF,
    output logic [31:0]      PC_IF,
    output logic [31:0]      PC_ID,
    output logic [31:0]      inst_ID,
    output logic             valid_ID,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Action taken on the IF/ID register this cycle, in priority order.
    typedef enum logic [1:0] {
        FD_FREEZE,  // global enable low: everything holds, nothing counts
        FD_STALL,   // hold contents; a same-cycle flush is dropped
        FD_FLUSH,   // insert a bubble
        FD_LOAD     // capture the fetched instruction
    } fd_action_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fd_action_e  fd_action;
    logic        pc_adv;
    logic [31:0] pc_next;

    // Resolve the IF/ID action from the hazard controls.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        fd_action = FD_LOAD;
        if (!reg_FD_EN) begin
            fd_action = FD_FREEZE;
        end else if (reg_FD_stall) begin
            fd_action = FD_STALL;
        end else if (reg_FD_flush) begin
            fd_action = FD_FLUSH;
        end
    end

    // Next fetch address: word-aligned redirect target or sequential advance.
    // Branch_taken only matters when the PC moves, because ID re-resolves a
    // held branch on the following cycle.
    always_comb begin
        pc_adv  = PC_EN_IF & reg_FD_EN;
        pc_next = PC_IF;
        if (pc_adv) begin
            if (Branch_taken) begin
                pc_next = branch_target & 32'hFFFF_FFFC;
            end else begin
                pc_next = PC_IF + 32'd4;  // modulo 2^32, so the top word wraps to 0
            end
        end
    end

    // PC register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_IF <= RESET_PC;
        end else begin
            PC_IF <= pc_next;
        end
    end

    // IF/ID pipeline register; reset leaves a bubble in ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_ID    <= 32'h0000_0000;
            inst_ID  <= NOP_INST;
            valid_ID <= 1'b0;
        end else begin
            unique case (fd_action)
                FD_FREEZE, FD_STALL: begin
                    PC_ID    <= PC_ID;
                    inst_ID  <= inst_ID;
                    valid_ID <= valid_ID;
                end
                FD_FLUSH: begin
                    PC_ID    <= PC_IF;
                    inst_ID  <= NOP_INST;
                    valid_ID <= 1'b0;
                end
                default: begin
                    PC_ID    <= PC_IF;
                    inst_ID  <= inst_IF;
                    valid_ID <= 1'b1;
                end
            endcase
        end
    end

    // Stall counter: counts applied stalls and sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (fd_action == FD_STALL && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Flush counter: counts applied flushes and sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (fd_action == FD_FLUSH && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed test of if_id_stage with a reference model.
// The model is updated on each rising edge from the control inputs. A compare
// process checks every DUT output against it on each falling edge. Literal
// expectations at key points keep the model honest. Counters use CNT_W=2 so
// that saturation shows up quickly.
module tb_if_id_stage;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned CMAX  = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk;
    logic             rst_n;
    logic             PC_EN_IF;
    logic             reg_FD_EN;
    logic             reg_FD_stall;
    logic             reg_FD_flush;
    logic             Branch_taken;
    logic [31:0]      branch_target;
    logic [31:0]      inst_IF;
    logic [31:0]      PC_IF;
    logic [31:0]      PC_ID;
    logic [31:0]      inst_ID;
    logic             valid_ID;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model state.
    logic [31:0] m_pc, m_pc_id, m_inst_id;
    logic        m_valid;
    int unsigned m_stall, m_flush;

    if_id_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PC_EN_IF     (PC_EN_IF),
        .reg_FD_EN    (reg_FD_EN),
        .reg_FD_stall (reg_FD_stall),
        .reg_FD_flush (reg_FD_flush),
        .Branch_taken (Branch_taken),
        .branch_target(branch_target),
        .inst_IF      (inst_IF),
        .PC_IF        (PC_IF),
        .PC_ID        (PC_ID),
        .inst_ID      (inst_ID),
        .valid_ID     (valid_ID),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the spec rules applied per edge. Reset discards everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc      <= 32'h0;
            m_pc_id   <= 32'h0;
            m_inst_id <= NOP;
            m_valid   <= 1'b0;
            m_stall   <= 0;
            m_flush   <= 0;
        end else begin
            if (PC_EN_IF && reg_FD_EN)
                m_pc <= Branch_taken ? {branch_target[31:2], 2'b00} : m_pc + 32'd4;
            if (reg_FD_EN) begin
                if (reg_FD_stall) begin
                    m_stall <= (m_stall < CMAX) ? m_stall + 1 : CMAX;
                end else if (reg_FD_flush) begin
                    m_pc_id   <= m_pc;
                    m_inst_id <= NOP;
                    m_valid   <= 1'b0;
                    m_flush   <= (m_flush < CMAX) ? m_flush + 1 : CMAX;
                end else begin
                    m_pc_id   <= m_pc;
                    m_inst_id <= inst_IF;
                    m_valid   <= 1'b1;
                end
            end
        end
    end

    // Compare process: outputs are stable on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model PC_IF",     PC_IF,            m_pc);
            check("model PC_ID",     PC_ID,            m_pc_id);
            check("model inst_ID",   inst_ID,          m_inst_id);
            check("model valid_ID",  {31'b0, valid_ID}, {31'b0, m_valid});
            check("model stall_cnt", {30'b0, stall_cnt}, m_stall);
            check("model flush_cnt", {30'b0, flush_cnt}, m_flush);
        end
    end

    // One clock period; on return the outputs reflect the edge that consumed
    // the inputs set before the call, and new inputs may be driven.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        PC_EN_IF      = 1'b1;
        reg_FD_EN     = 1'b1;
        reg_FD_stall  = 1'b0;
        reg_FD_flush  = 1'b0;
        Branch_taken  = 1'b0;
        branch_target = 32'h0;
    endtask

    initial begin
        rst_n   = 1'b0;
        inst_IF = 32'h00A0_0093;
        idle_ctrl();
        chk_on  = 1'b1;
        step();
        step();

        // Reset values.
        check("rst PC_IF",    PC_IF,              32'h0);
        check("rst PC_ID",    PC_ID,              32'h0);
        check("rst inst_ID",  inst_ID,            NOP);
        check("rst valid_ID", {31'b0, valid_ID},  32'h0);
        check("rst counters", {28'b0, stall_cnt, flush_cnt}, 32'h0);

        // Reset then run.
        rst_n = 1'b1;
        step();
        check("run PC_IF 4",  PC_IF,             32'h4);
        check("run valid",    {31'b0, valid_ID}, 32'h1);
        check("run inst_ID",  inst_ID,           32'h00A0_0093);
        check("run PC_ID 0",  PC_ID,             32'h0);
        step();
        check("run PC_IF 8",  PC_IF,             32'h8);
        check("run PC_ID 4",  PC_ID,             32'h4);

        // Load-use stall at PC_IF=8.
        PC_EN_IF = 1'b0; reg_FD_stall = 1'b1;
        step();
        check("stall PC_IF",  PC_IF,              32'h8);
        check("stall PC_ID",  PC_ID,              32'h4);
        check("stall cnt",    {30'b0, stall_cnt}, 32'h1);
        idle_ctrl();
        step();
        check("resume PC_IF", PC_IF,              32'hC);
        check("resume PC_ID", PC_ID,              32'h8);
        step();
        check("pre-br PC_IF", PC_IF,              32'h10);

        // Taken branch with flush at PC_IF=16.
        Branch_taken = 1'b1; branch_target = 32'h0000_0103; reg_FD_flush = 1'b1;
        step();
        check("br PC_IF",     PC_IF,              32'h100);
        check("br inst_ID",   inst_ID,            NOP);
        check("br valid",     {31'b0, valid_ID},  32'h0);
        check("br PC_ID",     PC_ID,              32'h10);
        check("br flush_cnt", {30'b0, flush_cnt}, 32'h1);
        idle_ctrl();
        inst_IF = 32'h0020_8113;
        step();
        check("tgt PC_ID",    PC_ID,              32'h100);
        check("tgt inst_ID",  inst_ID,            32'h0020_8113);

        // Stall wins over flush; branch ignored while the PC is held.
        inst_IF = 32'hDEAD_BEEF;
        reg_FD_stall = 1'b1; reg_FD_flush = 1'b1; PC_EN_IF = 1'b0;
        Branch_taken = 1'b1; branch_target = 32'h200;
        step();
        check("sw PC_IF",     PC_IF,              32'h104);
        check("sw PC_ID",     PC_ID,              32'h100);
        check("sw inst_ID",   inst_ID,            32'h0020_8113);
        check("sw stall_cnt", {30'b0, stall_cnt}, 32'h2);
        check("sw flush_cnt", {30'b0, flush_cnt}, 32'h1);

        // Freeze for 3 cycles: nothing moves, nothing counts.
        idle_ctrl();
        reg_FD_EN = 1'b0; reg_FD_stall = 1'b1;
        step();
        reg_FD_stall = 1'b0; reg_FD_flush = 1'b1;
        step();
        reg_FD_flush = 1'b0; Branch_taken = 1'b1; branch_target = 32'h400;
        step();
        check("frz PC_IF",    PC_IF,              32'h104);
        check("frz PC_ID",    PC_ID,              32'h100);
        check("frz inst_ID",  inst_ID,            32'h0020_8113);
        check("frz valid",    {31'b0, valid_ID},  32'h1);
        check("frz counters", {28'b0, stall_cnt, flush_cnt}, {28'b0, 2'd2, 2'd1});

        // Asynchronous reset pulse between edges.
        idle_ctrl();
        inst_IF = 32'h00A0_0093;
        rst_n = 1'b0;
        #1;
        check("arst PC_IF",   PC_IF,              32'h0);
        check("arst valid",   {31'b0, valid_ID},  32'h0);
        check("arst inst_ID", inst_ID,            NOP);
        check("arst counters", {28'b0, stall_cnt, flush_cnt}, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        check("post-rst PC_IF", PC_IF,            32'h4);

        // PC held while IF/ID still loads.
        PC_EN_IF = 1'b0;
        inst_IF  = 32'h0031_8193;
        step();
        check("pchold PC_IF",   PC_IF,            32'h4);
        check("pchold PC_ID",   PC_ID,            32'h4);
        check("pchold inst_ID", inst_ID,          32'h0031_8193);
        idle_ctrl();
        step();

        // Stall counter saturation.
        PC_EN_IF = 1'b0; reg_FD_stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("sat stall 3",  {30'b0, stall_cnt}, 32'h3);
        for (int i = 0; i < 2; i++) step();
        check("sat stall hold", {30'b0, stall_cnt}, 32'h3);

        // Flush counter saturation.
        idle_ctrl();
        reg_FD_flush = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("sat flush",    {30'b0, flush_cnt}, 32'h3);
        check("sat flush bubble", {31'b0, valid_ID}, 32'h0);

        // PC wrap from the top word.
        idle_ctrl();
        Branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step();
        check("wrap top",     PC_IF,              32'hFFFF_FFFC);
        idle_ctrl();
        step();
        check("wrap zero",    PC_IF,              32'h0);
        check("wrap PC_ID",   PC_ID,              32'hFFFF_FFFC);
        step();
        check("wrap next",    PC_IF,              32'h4);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
